// File: rtl/gpio_pulse_sequencer.sv
// Programmable multi-channel GPIO pulse sequencer with a busy-cycle watchdog
// and an input-change monitor, gated by the design enable.
module gpio_pulse_sequencer #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned REP_W  = 8,
    parameter int unsigned WD_W   = 24,
    parameter int unsigned CHG_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    // One spare bit so out-of-range selects are representable and can be rejected.
    input  logic [$clog2(NUM_CH):0] ch_sel,
    input  logic [CNT_W-1:0]        pre_delay,
    input  logic [CNT_W-1:0]        pulse_len,
    input  logic [CNT_W-1:0]        post_delay,
    input  logic [REP_W-1:0]        reps,
    input  logic [WD_W-1:0]         wd_limit,
    input  logic [NUM_CH-1:0]       gpio_obs,
    output logic [NUM_CH-1:0]       gpio_out,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic                    cfg_err,
    output logic                    change_evt,
    output logic [CHG_W-1:0]        change_cnt
);
    localparam int unsigned SEL_W = $clog2(NUM_CH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_PULSE, S_POST} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [SEL_W-1:0] ch_q;
    logic [CNT_W-1:0] pre_q, len_m1_q, post_q;
    logic [WD_W-1:0]  wd_lim_q, wd_cnt_q;
    logic             done_q, done_d, timeout_q, cfg_err_q;
    logic             accept, reject, wd_hit, rep_end;

    logic [NUM_CH-1:0] obs_q, prev_q;
    logic              seen_q, primed_q;
    logic [CHG_W-1:0]  chg_cnt_q;

    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state_q == S_IDLE && en && start) begin
            if (ch_sel < SEL_W'(NUM_CH)) accept = 1'b1;
            else                         reject = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            reps_q    <= '0;
            ch_q      <= '0;
            pre_q     <= '0;
            len_m1_q  <= '0;
            post_q    <= '0;
            wd_lim_q  <= '0;
            wd_cnt_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reps_q    <= reps_d;
            done_q    <= done_d;
            cfg_err_q <= reject;
            if (accept) begin
                ch_q      <= ch_sel;
                pre_q     <= pre_delay;
                len_m1_q  <= (pulse_len == '0) ? '0 : pulse_len - CNT_W'(1);
                post_q    <= post_delay;
                wd_lim_q  <= wd_limit;
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (state_q != S_IDLE) wd_cnt_q <= wd_cnt_q + WD_W'(1);
                if (wd_hit && en)      timeout_q <= 1'b1;
            end
        end
    end

    // The start cycle is spent in PRE, so the first pre-phase runs one cycle
    // longer than the pre-phases of repeats; cnt_q counts down remaining cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reps_d  = reps_q;
        done_d  = 1'b0;
        rep_end = 1'b0;
        wd_hit  = (state_q != S_IDLE) && (wd_lim_q != '0) &&
                  (wd_cnt_q == wd_lim_q - WD_W'(1));
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    cnt_d   = pre_delay;
                    reps_d  = (reps == '0) ? REP_W'(1) : reps;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = len_m1_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    if (post_q != '0) begin
                        state_d = S_POST;
                        cnt_d   = post_q - CNT_W'(1);
                    end else begin
                        rep_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_POST: begin
                if (cnt_q == '0) rep_end = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (rep_end) begin
            if (reps_q > REP_W'(1)) begin
                reps_d = reps_q - REP_W'(1);
                if (pre_q != '0) begin
                    state_d = S_PRE;
                    cnt_d   = pre_q - CNT_W'(1);
                end else begin
                    state_d = S_PULSE;
                    cnt_d   = len_m1_q;
                end
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (state_q != S_IDLE && (!en || wd_hit)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        gpio_out = '0;
        if (state_q == S_PULSE) gpio_out = NUM_CH'(1) << ch_q;
    end

    assign done    = done_q;
    assign timeout = timeout_q;
    assign cfg_err = cfg_err_q;

    // prev_q keeps following obs_q while disabled so a stale difference
    // cannot hold change_evt high during a freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            obs_q     <= '0;
            prev_q    <= '0;
            seen_q    <= 1'b0;
            primed_q  <= 1'b0;
            chg_cnt_q <= '0;
        end else begin
            prev_q   <= obs_q;
            primed_q <= seen_q;
            if (en) begin
                obs_q  <= gpio_obs;
                seen_q <= 1'b1;
            end
            if (accept)                                chg_cnt_q <= '0;
            else if (change_evt && chg_cnt_q != '1)    chg_cnt_q <= chg_cnt_q + CHG_W'(1);
        end
    end

    assign change_evt = primed_q && (obs_q != prev_q);
    assign change_cnt = chg_cnt_q;

endmodule

// File: tb/tb_gpio_pulse_sequencer.sv
// Scoreboard bench for gpio_pulse_sequencer: directed runs push expected
// output events; a negedge monitor pops and compares as the DUT produces them.
module tb_gpio_pulse_sequencer;
    localparam int K_GPIO = 0, K_BUSY = 1, K_DONE = 2, K_TO = 3, K_CFG = 4, K_CHG = 5;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0;
    logic [3:0]  ch_sel = '0;
    logic [15:0] pre_delay = '0, pulse_len = '0, post_delay = '0;
    logic [7:0]  reps = '0;
    logic [23:0] wd_limit = '0;
    logic [7:0]  gpio_obs = '0;

    logic [7:0]  gpio_out, b_gpio_out;
    logic        busy, done, timeout, cfg_err, change_evt;
    logic        b_busy, b_done, b_timeout, b_cfg_err, b_change_evt;
    logic [15:0] change_cnt;
    logic [1:0]  b_change_cnt;

    gpio_pulse_sequencer #(.NUM_CH(8), .CNT_W(16), .REP_W(8), .WD_W(24), .CHG_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .ch_sel(ch_sel),
        .pre_delay(pre_delay), .pulse_len(pulse_len), .post_delay(post_delay),
        .reps(reps), .wd_limit(wd_limit), .gpio_obs(gpio_obs),
        .gpio_out(gpio_out), .busy(busy), .done(done), .timeout(timeout),
        .cfg_err(cfg_err), .change_evt(change_evt), .change_cnt(change_cnt)
    );

    gpio_pulse_sequencer #(.NUM_CH(8), .CNT_W(16), .REP_W(8), .WD_W(24), .CHG_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start), .ch_sel(ch_sel),
        .pre_delay(pre_delay), .pulse_len(pulse_len), .post_delay(post_delay),
        .reps(reps), .wd_limit(wd_limit), .gpio_obs(gpio_obs),
        .gpio_out(b_gpio_out), .busy(b_busy), .done(b_done), .timeout(b_timeout),
        .cfg_err(b_cfg_err), .change_evt(b_change_evt), .change_cnt(b_change_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_on = 1'b0;
    logic [7:0] tv [4] = '{8'h01, 8'h81, 8'h80, 8'h00};

    function automatic string kname(input int k);
        case (k)
            K_GPIO:  return "gpio_out";
            K_BUSY:  return "busy";
            K_DONE:  return "done";
            K_TO:    return "timeout";
            K_CFG:   return "cfg_err";
            default: return "change_evt";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got cyc=%0d val=0x%0h, want no event", kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                failures++;
                $display("FAIL event_%s: got %s cyc=%0d val=0x%0h, want %s cyc=%0d val=0x%0h",
                         kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    logic [7:0] p_gpio = '0;
    logic       p_busy = 1'b0, p_to = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (gpio_out !== p_gpio) begin
                observe(K_GPIO, int'(gpio_out));
                p_gpio = gpio_out;
            end
            if (busy !== p_busy) begin
                observe(K_BUSY, int'(busy));
                p_busy = busy;
            end
            if (done !== 1'b0) observe(K_DONE, int'(done));
            if (timeout !== p_to) begin
                observe(K_TO, int'(timeout));
                p_to = timeout;
            end
            if (cfg_err !== 1'b0)    observe(K_CFG, int'(cfg_err));
            if (change_evt !== 1'b0) observe(K_CHG, int'(change_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one cycle, then scrambles the config inputs so any
    // failure to latch them shows up in the following events.
    task automatic do_start(input int ch, input int pre, input int len, input int post,
                            input int rp, input int wd);
        ch_sel     = 4'(ch);
        pre_delay  = 16'(pre);
        pulse_len  = 16'(len);
        post_delay = 16'(post);
        reps       = 8'(rp);
        wd_limit   = 24'(wd);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        ch_sel     = 4'd6;
        pre_delay  = 16'd7;
        pulse_len  = 16'd3;
        post_delay = 16'd5;
        reps       = 8'd9;
        wd_limit   = 24'd2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gpio_out"},   int'(gpio_out),     0);
        check({tag, "_busy"},       int'(busy),         0);
        check({tag, "_done"},       int'(done),         0);
        check({tag, "_timeout"},    int'(timeout),      0);
        check({tag, "_cfg_err"},    int'(cfg_err),      0);
        check({tag, "_change_evt"}, int'(change_evt),   0);
        check({tag, "_change_cnt"}, int'(change_cnt),   0);
        check({tag, "_b_gpio_out"}, int'(b_gpio_out),   0);
        check({tag, "_b_busy"},     int'(b_busy),       0);
        check({tag, "_b_flags"},    int'({b_done, b_timeout, b_cfg_err, b_change_evt}), 0);
        check({tag, "_b_chg_cnt"},  int'(b_change_cnt), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_time_limit: got no completion, want finish");
        $fatal(1, "time limit");
    end

    initial begin
        int  n;
        ev_t e;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");
        en     = 1'b1;
        mon_on = 1'b1;
        tick(3);

        // 1: ch3, pre=100, len=100, single pulse
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_GPIO, n + 101, 8'h08);
        expect_ev(K_GPIO, n + 201, 0);
        expect_ev(K_BUSY, n + 201, 0);
        expect_ev(K_DONE, n + 201, 1);
        do_start(3, 100, 100, 0, 1, 0);
        tick(210);

        // 2: three 1-cycle pulses on bit 0, 3 cycles apart
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_GPIO, n + 1, 1);
        expect_ev(K_GPIO, n + 2, 0);
        expect_ev(K_GPIO, n + 4, 1);
        expect_ev(K_GPIO, n + 5, 0);
        expect_ev(K_GPIO, n + 7, 1);
        expect_ev(K_GPIO, n + 8, 0);
        expect_ev(K_BUSY, n + 10, 0);
        expect_ev(K_DONE, n + 10, 1);
        do_start(0, 0, 0, 2, 3, 0);
        tick(15);

        // 3: watchdog aborts after 50 busy cycles; next start clears timeout
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_GPIO, n + 11, 8'h20);
        expect_ev(K_GPIO, n + 50, 0);
        expect_ev(K_BUSY, n + 50, 0);
        expect_ev(K_TO,   n + 50, 1);
        do_start(5, 10, 1000, 0, 1, 50);
        tick(55);
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_TO,   n, 0);
        expect_ev(K_GPIO, n + 1, 8'h02);
        expect_ev(K_GPIO, n + 2, 0);
        expect_ev(K_BUSY, n + 2, 0);
        expect_ev(K_DONE, n + 2, 1);
        do_start(1, 0, 1, 0, 1, 0);
        tick(5);

        // 3b: watchdog expiry coincides with end of POST, watchdog wins
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_GPIO, n + 1, 1);
        expect_ev(K_GPIO, n + 2, 0);
        expect_ev(K_BUSY, n + 4, 0);
        expect_ev(K_TO,   n + 4, 1);
        do_start(0, 0, 1, 2, 1, 4);
        tick(8);

        // 4: out-of-range channel rejected; start during busy ignored
        n = cyc + 1;
        expect_ev(K_CFG, n, 1);
        do_start(9, 0, 1, 0, 1, 0);
        check("cfg_reject_busy", int'(busy), 0);
        tick(3);
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_TO,   n, 0);
        expect_ev(K_GPIO, n + 1, 8'h04);
        expect_ev(K_GPIO, n + 2, 0);
        expect_ev(K_GPIO, n + 3, 8'h04);
        expect_ev(K_GPIO, n + 4, 0);
        expect_ev(K_BUSY, n + 5, 0);
        expect_ev(K_DONE, n + 5, 1);
        do_start(2, 0, 1, 1, 2, 0);
        ch_sel    = 4'd6;
        reps      = 8'd5;
        pulse_len = 16'd4;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        tick(8);

        // 5: input-change monitor, then frozen while disabled
        check("chg_cnt_before", int'(change_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            gpio_obs = tv[i];
            expect_ev(K_CHG, cyc + 1, i);
            tick(3);
        end
        check("chg_cnt_after4", int'(change_cnt), 4);
        check("chg_cnt_sat2",   int'(b_change_cnt), 3);
        en = 1'b0;
        gpio_obs = 8'h55;
        tick(2);
        gpio_obs = 8'hAA;
        tick(2);
        gpio_obs = 8'h00;
        tick(1);
        en = 1'b1;
        tick(3);
        check("chg_cnt_frozen", int'(change_cnt), 4);
        check("chg_cnt_sat2_frozen", int'(b_change_cnt), 3);

        // 6a: reset mid-PULSE
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_GPIO, n + 3, 8'h10);
        expect_ev(K_GPIO, n + 8, 0);
        expect_ev(K_BUSY, n + 8, 0);
        do_start(4, 2, 20, 0, 1, 0);
        tick(7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset("rst_mid");
        tick(5);

        // 6b: enable dropped mid-PRE
        n = cyc + 1;
        expect_ev(K_BUSY, n, 1);
        expect_ev(K_BUSY, n + 5, 0);
        do_start(7, 30, 5, 0, 1, 0);
        tick(4);
        en = 1'b0;
        tick(1);
        check("en_abort_gpio", int'(gpio_out), 0);
        check("en_abort_busy", int'(busy), 0);
        tick(2);
        en = 1'b1;
        tick(40);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_%s: got no event, want cyc=%0d val=0x%0h", kname(e.kind), e.cyc, e.val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
